// File: rtl/score_keeper.sv
// Match-state keeper for Pong: scores, serve delay, winner and ball hold.
// Optional macro AUTO_RESTART_EN: OVER restarts itself after RESTART_FRAMES frame ticks.
module score_keeper #(
   parameter int WIN_SCORE      = 9,
   parameter int SERVE_FRAMES   = 60,
   parameter int RESTART_FRAMES = 180
) (
   input  logic       PixelClock,
   input  logic       Reset,
   input  logic       frameTick,
   input  logic       point1,
   input  logic       point2,
   input  logic       startBtn,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic       holdBall,
   output logic       gameOver,
   output logic [1:0] winner
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SERVE = 2'd1;
   localparam logic [1:0] PLAY  = 2'd2;
   localparam logic [1:0] OVER  = 2'd3;

   localparam logic [3:0] WIN          = 4'(WIN_SCORE);
   localparam logic [7:0] SERVE_LOAD   = 8'(SERVE_FRAMES);
   localparam logic [7:0] RESTART_LOAD = 8'(RESTART_FRAMES);

   logic [1:0] state, state_n;
   logic [3:0] score1_n, score2_n;
   logic [1:0] winner_n;
   logic [7:0] count, count_n;
   logic       prev_p1, prev_p2, prev_start;
   logic       p1_edge, p2_edge, start_edge;

   assign p1_edge    = point1 & ~prev_p1;
   assign p2_edge    = point2 & ~prev_p2;
   assign start_edge = startBtn & ~prev_start;

   // Next-state and next-score logic; the counter is reloaded on every SERVE entry.
   always_comb begin
      state_n  = state;
      score1_n = score1;
      score2_n = score2;
      winner_n = winner;
      count_n  = count;
      case (state)
         IDLE: begin
            if (start_edge) begin
               state_n = SERVE;
               count_n = SERVE_LOAD;
            end
         end
         SERVE: begin
            if (count == 8'd0)
               state_n = PLAY;
            else if (frameTick)
               count_n = count - 8'd1;
         end
         PLAY: begin
            if (p1_edge && p2_edge) begin
               state_n = SERVE;
               count_n = SERVE_LOAD;
            end else if (p1_edge || p2_edge) begin
               if (p1_edge)
                  score1_n = score1 + 4'd1;
               else
                  score2_n = score2 + 4'd1;
               if ((p1_edge && score1_n == WIN) || (p2_edge && score2_n == WIN)) begin
                  state_n  = OVER;
                  winner_n = p1_edge ? 2'b01 : 2'b10;
                  count_n  = RESTART_LOAD;
               end else begin
                  state_n = SERVE;
                  count_n = SERVE_LOAD;
               end
            end
         end
         OVER: begin
            if (start_edge) begin
               state_n  = SERVE;
               score1_n = 4'd0;
               score2_n = 4'd0;
               winner_n = 2'b00;
               count_n  = SERVE_LOAD;
            end
`ifdef AUTO_RESTART_EN
            else if (count == 8'd0) begin
               state_n  = SERVE;
               score1_n = 4'd0;
               score2_n = 4'd0;
               winner_n = 2'b00;
               count_n  = SERVE_LOAD;
            end else if (frameTick) begin
               count_n = count - 8'd1;
            end
`else
            else begin
               count_n = count;
            end
`endif
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they move on the sampling edge.
   always_ff @(posedge PixelClock or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         score1     <= 4'd0;
         score2     <= 4'd0;
         winner     <= 2'b00;
         count      <= 8'd0;
         holdBall   <= 1'b1;
         gameOver   <= 1'b0;
         prev_p1    <= 1'b0;
         prev_p2    <= 1'b0;
         prev_start <= 1'b0;
      end else begin
         state      <= state_n;
         score1     <= score1_n;
         score2     <= score2_n;
         winner     <= winner_n;
         count      <= count_n;
         holdBall   <= (state_n != PLAY);
         gameOver   <= (state_n == OVER);
         prev_p1    <= point1;
         prev_p2    <= point2;
         prev_start <= startBtn;
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with WIN_SCORE=3, SERVE_FRAMES=2, RESTART_FRAMES=4.
// Follows AUTO_RESTART_EN the same way as the design build.
module tb_score_keeper;

   logic       PixelClock = 1'b0;
   logic       Reset      = 1'b1;
   logic       frameTick  = 1'b0;
   logic       point1     = 1'b0;
   logic       point2     = 1'b0;
   logic       startBtn   = 1'b0;
   logic [3:0] score1, score2;
   logic       holdBall, gameOver;
   logic [1:0] winner;

   int compared   = 0;
   int mismatched = 0;

   score_keeper #(.WIN_SCORE(3), .SERVE_FRAMES(2), .RESTART_FRAMES(4)) dut (
      .PixelClock(PixelClock),
      .Reset(Reset),
      .frameTick(frameTick),
      .point1(point1),
      .point2(point2),
      .startBtn(startBtn),
      .score1(score1),
      .score2(score2),
      .holdBall(holdBall),
      .gameOver(gameOver),
      .winner(winner)
   );

   always #5 PixelClock = ~PixelClock;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One clock with the given inputs; returns 1 time unit after the edge.
   task automatic applyStimulus(input logic tick, input logic p1, input logic p2, input logic start);
      frameTick = tick;
      point1    = p1;
      point2    = p2;
      startBtn  = start;
      @(posedge PixelClock);
      #1;
   endtask

   // Two serve frames then the edge that enters PLAY.
   task automatic serveToPlay(input string tag);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput({tag, "_hold_before"}, 32'(holdBall), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput({tag, "_play"}, 32'(holdBall), 32'd0);
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("rst_score1", 32'(score1), 32'd0);
      checkOutput("rst_score2", 32'(score2), 32'd0);
      checkOutput("rst_winner", 32'(winner), 32'd0);
      checkOutput("rst_hold", 32'(holdBall), 32'd1);
      checkOutput("rst_over", 32'(gameOver), 32'd0);
      Reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      // Points are ignored while idle.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("idle_pt_score1", 32'(score1), 32'd0);
      checkOutput("idle_hold", 32'(holdBall), 32'd1);

      // Start edge with a coincident frame tick: that tick must not count.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("start_hold", 32'(holdBall), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      serveToPlay("serve1");

      // A held point counts once.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("p1_score1", 32'(score1), 32'd1);
      checkOutput("p1_hold", 32'(holdBall), 32'd1);
      for (int i = 0; i < 49; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("p1_held_score1", 32'(score1), 32'd1);
      serveToPlay("serve2");

      // Simultaneous points: no-score rally.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("both_score1", 32'(score1), 32'd1);
      checkOutput("both_score2", 32'(score2), 32'd0);
      checkOutput("both_hold", 32'(holdBall), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      serveToPlay("serve3");

      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("p2a_score2", 32'(score2), 32'd1);
      // Point during SERVE is ignored.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("serve_pt_score1", 32'(score1), 32'd1);
      serveToPlay("serve4");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("p2b_score2", 32'(score2), 32'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      serveToPlay("serve5");

      // Winning point.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("win_score2", 32'(score2), 32'd3);
      checkOutput("win_winner", 32'(winner), 32'd2);
      checkOutput("win_over", 32'(gameOver), 32'd1);
      checkOutput("win_hold", 32'(holdBall), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("over_pt_score1", 32'(score1), 32'd1);
      checkOutput("over_pt_winner", 32'(winner), 32'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef AUTO_RESTART_EN
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("auto_still_over", 32'(gameOver), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("auto_over", 32'(gameOver), 32'd0);
      checkOutput("auto_score1", 32'(score1), 32'd0);
      checkOutput("auto_score2", 32'(score2), 32'd0);
      checkOutput("auto_winner", 32'(winner), 32'd0);
      checkOutput("auto_hold", 32'(holdBall), 32'd1);
`else
      for (int i = 0; i < 1000; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("noauto_over", 32'(gameOver), 32'd1);
      checkOutput("noauto_winner", 32'(winner), 32'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("restart_over", 32'(gameOver), 32'd0);
      checkOutput("restart_score1", 32'(score1), 32'd0);
      checkOutput("restart_score2", 32'(score2), 32'd0);
      checkOutput("restart_winner", 32'(winner), 32'd0);
      checkOutput("restart_hold", 32'(holdBall), 32'd1);
`endif
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      serveToPlay("serve6");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      serveToPlay("serve7");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("pre_rst_score1", 32'(score1), 32'd2);

      // Asynchronous reset mid-SERVE takes effect without a clock edge.
      Reset = 1'b1;
      #1;
      checkOutput("async_score1", 32'(score1), 32'd0);
      checkOutput("async_winner", 32'(winner), 32'd0);
      checkOutput("async_hold", 32'(holdBall), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      Reset = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("post_rst_idle_hold", 32'(holdBall), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
